// File: rtl/svm_feature_sequencer_if.sv
// Byte-stream input and tagged-result output handshakes of the SVM feature sequencer.
interface svm_feature_sequencer_if #(
    parameter int unsigned TAG_W = 16
) ();
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_class;
    logic             res_err;
    logic [TAG_W-1:0] res_tag;

    // Producer of bytes / consumer of results
    modport master (
        output in_data, in_valid, res_ready,
        input  in_ready, res_valid, res_class, res_err, res_tag
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid, res_ready,
        output in_ready, res_valid, res_class, res_err, res_tag
    );
endinterface

// File: rtl/svm_feature_sequencer.sv
// Assembles an 8-byte sample into four classifier features, waits the classifier
// latency, then returns the sampled decision as a tagged result.
module svm_feature_sequencer #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned TAG_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    svm_feature_sequencer_if.slave  bus,
    output logic [15:0]             f1,
    output logic [14:0]             f2,
    output logic [9:0]              f3,
    output logic [12:0]             f4,
    input  logic                    class_in,
    output logic                    busy
);

    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             load_feat;
    logic             sample;
    logic             tag_inc;

    logic [2:0]       byte_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             frame_err;
    logic [15:0]      sh_f1;
    logic [14:0]      sh_f2;
    logic [9:0]       sh_f3;
    logic [4:0]       sh_f4_hi;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-edge action strobes; flush overrides everything
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_feat  = 1'b0;
        sample     = 1'b0;
        tag_inc    = 1'b0;
        case (state)
            ST_RST: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (byte_cnt == 3'd7) begin
                        load_feat  = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    sample     = 1'b1;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    tag_inc    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
        if (flush) begin
            state_next = ST_LOAD;
            accept     = 1'b0;
            load_feat  = 1'b0;
            sample     = 1'b0;
            tag_inc    = 1'b0;
        end
    end

    // Byte counter and shadow assembly; upper bits are only inspected for the error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= 3'd0;
            frame_err <= 1'b0;
            sh_f1     <= 16'd0;
            sh_f2     <= 15'd0;
            sh_f3     <= 10'd0;
            sh_f4_hi  <= 5'd0;
            f1        <= 16'd0;
            f2        <= 15'd0;
            f3        <= 10'd0;
            f4        <= 13'd0;
        end else begin
            if (flush) begin
                byte_cnt <= 3'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 3'd1;
            end
            if (accept) begin
                case (byte_cnt)
                    3'd0: begin
                        sh_f1[15:8] <= bus.in_data;
                        frame_err   <= 1'b0;
                    end
                    3'd1: sh_f1[7:0] <= bus.in_data;
                    3'd2: begin
                        sh_f2[14:8] <= bus.in_data[6:0];
                        frame_err   <= frame_err | bus.in_data[7];
                    end
                    3'd3: sh_f2[7:0] <= bus.in_data;
                    3'd4: begin
                        sh_f3[9:8] <= bus.in_data[1:0];
                        frame_err  <= frame_err | (|bus.in_data[7:2]);
                    end
                    3'd5: sh_f3[7:0] <= bus.in_data;
                    3'd6: begin
                        sh_f4_hi  <= bus.in_data[4:0];
                        frame_err <= frame_err | (|bus.in_data[7:5]);
                    end
                    3'd7: begin
                        f1 <= sh_f1;
                        f2 <= sh_f2;
                        f3 <= sh_f3;
                        f4 <= {sh_f4_hi, bus.in_data};
                    end
                endcase
            end
        end
    end

    // Latency countdown and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            bus.res_class <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.res_tag   <= '0;
        end else begin
            if (load_feat) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (sample) begin
                bus.res_class <= class_in;
                bus.res_err   <= frame_err;
            end
            if (tag_inc) begin
                bus.res_tag <= bus.res_tag + TAG_W'(1);
            end
        end
    end

    // Status outputs registered from the next state so they mirror the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready  <= 1'b0;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.in_ready  <= (state_next == ST_LOAD);
            bus.res_valid <= (state_next == ST_OUT);
            busy          <= (state_next == ST_WAIT) || (state_next == ST_OUT);
        end
    end

endmodule

// File: doc/svm_feature_sequencer.md
Name: svm_feature_sequencer

Overview:
- Front-end and back-end for the four-feature SVM classifier (f1 16b, f2 15b, f3 10b, f4 13b, single class bit out).
- Accepts a byte stream carrying one sample, assembles it, and presents all four features to the classifier at the same time.
- Waits a fixed pipeline latency, then samples the classifier's decision and returns it as a tagged result over a valid/ready handshake.

Parameters:
- LATENCY, 2, clock edges from feature update to the edge that samples class_in (1..15).
- TAG_W, 16, width of the sample-sequence tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: discards the partial frame or pending result and returns to LOAD.
- in_data  in  8  feature byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- f1  out  16  feature 1 to classifier.
- f2  out  15  feature 2 to classifier.
- f3  out  10  feature 3 to classifier.
- f4  out  13  feature 4 to classifier.
- class_in  in  1  classifier decision (class_out).
- res_valid  out  1  result is available.
- res_ready  in  1  consumer takes the result.
- res_class  out  1  captured decision.
- res_err  out  1  the sample had nonzero bits above a feature's width.
- res_tag  out  TAG_W  sample sequence number.
- busy  out  1  high in WAIT or OUT.

Behaviour:
- Frame format: 8 bytes. Each feature is 16 bits, sent MSB byte first, in order f1, f2, f3, f4.
- Feature width handling: f2 takes the low 15 bits, f3 the low 10, f4 the low 13.
- Error detection: if any discarded upper bit is 1 (f2 bit15, f3 bits15:10, f4 bits15:13), a frame error flag is set. The flag is cleared at the start of each frame.
- A byte is accepted on a rising edge where in_valid and in_ready are both high.
- Assembly happens in shadow registers. f1..f4 change only on the edge that accepts byte 8, all at once, and then hold until the next complete frame. Partial frames never disturb f1..f4.
- FSM:
  - LOAD: in_ready=1. A byte counter runs 0..7. Accepting byte 8 (counter=7) loads f1..f4, loads wait counter = LATENCY-1, and moves to WAIT.
  - WAIT: in_ready=0. Counter decrements each edge. On the edge where counter=0, class_in is sampled into res_class, the frame error flag goes to res_err, and the state moves to OUT. So if byte 8 is accepted at edge T, class_in is sampled at edge T+LATENCY and res_valid is high from just after T+LATENCY.
  - OUT: res_valid=1. res_class, res_err and res_tag are stable until the handshake. On an edge with res_ready=1: res_tag increments (wrapping at 2^TAG_W-1 to 0), state returns to LOAD, and in_ready rises the following cycle. No same-cycle bypass of byte acceptance.
- in_valid in WAIT or OUT is ignored; no byte is consumed.
- flush=1 at any edge: state goes to LOAD, the byte counter clears, and res_valid drops. Flush wins over a simultaneous byte accept or result handshake. f1..f4 and res_tag are unchanged.
- Reset (rst_n low, asynchronous):
  - f1..f4=0, res_class=0, res_err=0, res_tag=0, res_valid=0, busy=0.
  - in_ready=0 while rst_n is low and goes to 1 on the first clk edge after release (state LOAD).
  - Reset during WAIT or OUT discards the sample.
- in_ready, res_valid and busy are decoded from registered state only. There is no combinational path from in_valid or res_ready to any output.

Test Plan:
- Basic frame: reset, then send bytes 00 25 00 01 00 0A 00 03 with LATENCY=2, and drive class_in=1 two edges after byte 8.
  - Expected: f1=0x0025, f2=1, f3=10, f4=3 appear on the same edge.
  - Expected: res_valid=1 at T+2 with res_class=1, res_err=0, res_tag=0.
- Back-pressure: hold res_ready=0 for 5 cycles, toggle class_in, and send in_valid bytes.
  - Expected: res_class, res_tag and res_valid are stable, in_ready=0, and no bytes are consumed.
  - Then res_ready=1 for one cycle. Expected: res_tag→1 and in_ready=1 on the next cycle.
- Width error: f3 bytes = 04 00.
  - Expected: f3=0x000, res_err=1. The next clean frame reports res_err=0.
- Flush mid-frame: send 3 bytes, pulse flush, then send a full frame of 8 bytes.
  - Expected: f1..f4 reflect only the new frame; res_tag is not incremented by the aborted frame.
- Tag wrap: TAG_W=2, run 5 frames.
  - Expected: tags 0,1,2,3,0.
- Async reset in WAIT: assert rst_n low between clock edges.
  - Expected: all outputs 0 immediately; in_ready=1 one edge after release; no result is emitted.
